// File: rtl/pcie_dma_arb.sv
// Round-robin, burst-locked arbiter feeding the PCIe DMA engine through a small output FIFO.
// Each FIFO entry carries the beat data, its last flag and the originating requester id.
module pcie_dma_arb #(
  parameter int NREQ       = 2,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 2,
  parameter int IDW        = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic [NREQ-1:0]            i_req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NREQ-1:0]            i_req_last,
  output logic [NREQ-1:0]            o_req_ready,
  output logic                       o_dma_valid,
  output logic [DATA_WIDTH-1:0]      o_dma_data,
  output logic                       o_dma_last,
  output logic [IDW-1:0]             o_dma_id,
  input  logic                       i_dma_ready,
  output logic [NREQ-1:0]            o_grant,
  output logic                       o_busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state;
  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        owner;
  logic [IDW-1:0]        winner;
  logic [IDW-1:0]        sel;
  logic [IDW-1:0]        next_rr;
  logic [IDW:0]          cand;
  logic                  found;
  logic [NREQ-1:0]       ready_c;
  logic                  space;
  logic                  push;
  logic                  pop;
  logic                  push_last;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] req_data [NREQ];

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];
  logic [IDW-1:0]        mem_id   [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < NREQ; k++) begin
      req_data[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Cyclic scan starting at rr_ptr; the candidate index is folded back below NREQ
  // by a single subtraction since rr_ptr + i never reaches 2*NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && i_req_valid[cand[IDW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDW-1:0];
      end
    end
  end

  assign space = (count < CW'(FIFO_DEPTH));
  assign pop   = i_dma_ready && (count != '0);

  always_comb begin
    ready_c = '0;
    sel     = winner;
    push    = 1'b0;
    if (state == IDLE) begin
      if (found && space) begin
        ready_c[winner] = 1'b1;
        push            = 1'b1;
      end
    end else begin
      sel            = owner;
      ready_c[owner] = space;
      push           = space && i_req_valid[owner];
    end
  end

  assign push_last   = i_req_last[sel];
  assign push_data   = req_data[sel];
  assign next_rr     = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
  assign o_req_ready = i_nrst ? ready_c : '0;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state   <= IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      o_grant <= '0;
    end else if (push) begin
      if (push_last) begin
        state   <= IDLE;
        rr_ptr  <= next_rr;
        o_grant <= '0;
      end else begin
        state   <= LOCKED;
        owner   <= sel;
        o_grant <= NREQ'(1) << sel;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_last[wr_ptr] <= push_last;
      mem_id[wr_ptr]   <= sel;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head fields read as zero while empty so reset leaves every output at 0.
  assign o_dma_valid = (count != '0);
  assign o_dma_data  = o_dma_valid ? mem_data[rd_ptr] : '0;
  assign o_dma_last  = o_dma_valid ? mem_last[rd_ptr] : 1'b0;
  assign o_dma_id    = o_dma_valid ? mem_id[rd_ptr]   : '0;
  assign o_busy      = (state == LOCKED) || o_dma_valid;

endmodule

// File: tb/tb_pcie_dma_arb.sv
// Bench for pcie_dma_arb: a 2-requester and a 3-requester instance, each checked every cycle
// against a queue-based model of the arbitration rules, plus directed literal expectations.
module tb_pcie_dma_arb;

  logic clk;
  logic rst_n;

  logic [2:0]  v    [2];
  logic [2:0]  l    [2];
  logic [63:0] dat  [2][3];
  logic        drdy [2];

  logic [2:0]  rdy  [2];
  logic [2:0]  gnt  [2];
  logic [1:0]  did  [2];
  logic        dv   [2];
  logic        dl   [2];
  logic        bsy  [2];
  logic [63:0] ddat [2];

  logic [1:0]  rdy_a, gnt_a;
  logic        id_a, dv_a, dl_a, bsy_a;
  logic [63:0] ddat_a;
  logic [2:0]  rdy_b, gnt_b;
  logic [1:0]  id_b;
  logic        dv_b, dl_b, bsy_b;
  logic [63:0] ddat_b;

  pcie_dma_arb #(.NREQ(2), .DATA_WIDTH(64), .FIFO_DEPTH(2)) dut_a (
    .i_clk(clk), .i_nrst(rst_n),
    .i_req_valid(v[0][1:0]), .i_req_data({dat[0][1], dat[0][0]}), .i_req_last(l[0][1:0]),
    .o_req_ready(rdy_a), .o_dma_valid(dv_a), .o_dma_data(ddat_a), .o_dma_last(dl_a),
    .o_dma_id(id_a), .i_dma_ready(drdy[0]), .o_grant(gnt_a), .o_busy(bsy_a)
  );

  pcie_dma_arb #(.NREQ(3), .DATA_WIDTH(64), .FIFO_DEPTH(2)) dut_b (
    .i_clk(clk), .i_nrst(rst_n),
    .i_req_valid(v[1]), .i_req_data({dat[1][2], dat[1][1], dat[1][0]}), .i_req_last(l[1]),
    .o_req_ready(rdy_b), .o_dma_valid(dv_b), .o_dma_data(ddat_b), .o_dma_last(dl_b),
    .o_dma_id(id_b), .i_dma_ready(drdy[1]), .o_grant(gnt_b), .o_busy(bsy_b)
  );

  always_comb begin
    rdy[0] = {1'b0, rdy_a}; gnt[0] = {1'b0, gnt_a}; did[0] = {1'b0, id_a};
    dv[0] = dv_a; dl[0] = dl_a; bsy[0] = bsy_a; ddat[0] = ddat_a;
    rdy[1] = rdy_b; gnt[1] = gnt_b; did[1] = id_b;
    dv[1] = dv_b; dl[1] = dl_b; bsy[1] = bsy_b; ddat[1] = ddat_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int id; bit last; logic [63:0] data; } beat_t;
  typedef struct { logic [63:0] data; bit last; int gap; } stim_t;

  beat_t       mq      [2][$];
  int          mrr     [2];
  int          mown    [2];
  bit          mlock   [2];
  stim_t       sq      [2][3][$];
  bit          acc     [2][3];
  int          acc_cnt [2][3];
  int          outlog  [2][$];
  logic [63:0] datlog  [2][$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string nm, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
    end
  endtask

  function automatic string id_str(input int dd);
    string s = "";
    for (int i = 0; i < outlog[dd].size(); i++) s = {s, $sformatf("%0d", outlog[dd][i])};
    return s;
  endfunction

  function automatic string data_str(input int dd);
    string s = "";
    for (int i = 0; i < datlog[dd].size(); i++) s = {s, $sformatf("%0h,", datlog[dd][i])};
    return s;
  endfunction

  // Expected behaviour for one cycle, then the model advances as if the clock edge occurred.
  task automatic model_cycle(input int dd);
    int n = (dd == 0) ? 2 : 3;
    int cnt = mq[dd].size();
    int win = -1;
    int sel;
    bit space;
    logic [2:0] er = '0;
    logic [2:0] eg = '0;
    if (!rst_n) begin
      chk($sformatf("rst_ready%0d", dd), rdy[dd], 0);
      chk($sformatf("rst_valid%0d", dd), dv[dd], 0);
      chk($sformatf("rst_grant%0d", dd), gnt[dd], 0);
      chk($sformatf("rst_busy%0d", dd), bsy[dd], 0);
      mq[dd].delete();
      mlock[dd] = 0; mrr[dd] = 0; mown[dd] = 0;
      for (int k = 0; k < 3; k++) acc[dd][k] = 0;
      return;
    end
    space = (cnt < 2);
    if (!mlock[dd]) begin
      for (int i = 0; i < n; i++) begin
        int k = (mrr[dd] + i) % n;
        if (v[dd][k]) begin win = k; break; end
      end
      if (win >= 0 && space) er[win] = 1'b1;
      sel = win;
    end else begin
      er[mown[dd]] = space;
      eg[mown[dd]] = 1'b1;
      sel = mown[dd];
    end
    chk($sformatf("ready%0d", dd), rdy[dd], er);
    chk($sformatf("grant%0d", dd), gnt[dd], eg);
    chk($sformatf("dma_valid%0d", dd), dv[dd], cnt != 0);
    chk($sformatf("busy%0d", dd), bsy[dd], mlock[dd] || cnt != 0);
    if (cnt != 0) begin
      chk($sformatf("dma_data%0d", dd), ddat[dd], mq[dd][0].data);
      chk($sformatf("dma_last%0d", dd), dl[dd], mq[dd][0].last);
      chk($sformatf("dma_id%0d", dd), did[dd], mq[dd][0].id);
    end
    for (int k = 0; k < n; k++) begin
      acc[dd][k] = v[dd][k] && rdy[dd][k];
      if (acc[dd][k]) acc_cnt[dd][k]++;
    end
    if (dv[dd] && drdy[dd]) begin
      outlog[dd].push_back(int'(did[dd]));
      datlog[dd].push_back(ddat[dd]);
    end
    if (cnt != 0 && drdy[dd]) void'(mq[dd].pop_front());
    if (sel >= 0 && er[sel] && v[dd][sel]) begin
      mq[dd].push_back('{sel, l[dd][sel], dat[dd][sel]});
      if (l[dd][sel]) begin
        mlock[dd] = 0;
        mrr[dd]   = (sel + 1) % n;
      end else begin
        mlock[dd] = 1;
        mown[dd]  = sel;
      end
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0);
    model_cycle(1);
  end

  task automatic drive();
    for (int dd = 0; dd < 2; dd++) begin
      for (int k = 0; k < 3; k++) begin
        if (acc[dd][k] && sq[dd][k].size() != 0) void'(sq[dd][k].pop_front());
        acc[dd][k] = 0;
        v[dd][k] = 1'b0;
        if (sq[dd][k].size() != 0) begin
          if (sq[dd][k][0].gap > 0) begin
            sq[dd][k][0].gap--;
          end else begin
            v[dd][k]   = 1'b1;
            dat[dd][k] = sq[dd][k][0].data;
            l[dd][k]   = sq[dd][k][0].last;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic add_beat(input int dd, input int k, input logic [63:0] d, input bit last, input int gap);
    sq[dd][k].push_back('{d, last, gap});
  endtask

  task automatic clear_stim();
    for (int dd = 0; dd < 2; dd++) begin
      for (int k = 0; k < 3; k++) begin
        sq[dd][k].delete();
        v[dd][k] = 1'b0; l[dd][k] = 1'b0; dat[dd][k] = '0;
        acc_cnt[dd][k] = 0;
      end
      outlog[dd].delete();
      datlog[dd].delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_stim();
    drdy[0] = 1'b0; drdy[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int dd, input int limit, input string nm, output int cycles);
    int c = 0;
    while ((sq[dd][0].size() + sq[dd][1].size() + sq[dd][2].size() + mq[dd].size()) != 0 && c < limit) begin
      step();
      c++;
    end
    cycles = c;
    chk({nm, "_timeout"}, c < limit, 1);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    drdy[0] = 1'b0; drdy[1] = 1'b0;
    clear_stim();

    // Reset state, then a single-beat burst from req0
    do_reset();
    chk("idle_valid", dv[0], 0);
    chk("idle_grant", gnt[0], 0);
    chk("idle_busy", bsy[0], 0);
    chk("idle_data", ddat[0], 0);
    chk("idle_ready", rdy[0], 0);
    add_beat(0, 0, 64'h1111_2222_3333_4444, 1'b1, 0);
    drdy[0] = 1'b1;
    drive();
    #1;
    chk("t1_ready_same_cycle", rdy[0][0], 1);
    step();
    #1;
    chk("t1_valid", dv[0], 1);
    chk("t1_data", ddat[0], 64'h1111_2222_3333_4444);
    chk("t1_id", did[0], 0);
    chk("t1_last", dl[0], 1);
    add_beat(0, 0, 64'h50, 1'b1, 0);
    add_beat(0, 1, 64'h51, 1'b1, 0);
    drive();
    wait_done(0, 50, "t1", cyc);
    chk_str("t1_rr_after_single", id_str(0), "010");

    // Both requesters streaming 3-beat bursts
    do_reset();
    drdy[0] = 1'b1;
    for (int b = 0; b < 6; b++) add_beat(0, 0, 64'hA00 + 64'(b), (b % 3) == 2, 0);
    for (int b = 0; b < 3; b++) add_beat(0, 1, 64'hB00 + 64'(b), b == 2, 0);
    drive();
    wait_done(0, 50, "t2", cyc);
    chk_str("t2_burst_order", id_str(0), "000111000");
    chk("t2_cycles", cyc, 10);

    // Backpressure with a 2-entry FIFO
    do_reset();
    for (int b = 0; b < 4; b++) add_beat(0, 0, 64'hA1 + 64'(b), b == 3, 0);
    drive();
    repeat (3) step();
    chk("t3_accepted", acc_cnt[0][0], 2);
    chk("t3_ready_full", rdy[0][0], 0);
    chk("t3_head", ddat[0], 64'hA1);
    drdy[0] = 1'b1;
    #1;
    chk("t3_no_passthrough", rdy[0][0], 0);
    step();
    drdy[0] = 1'b0;
    #1;
    chk("t3_ready_back", rdy[0][0], 1);
    chk("t3_head2", ddat[0], 64'hA2);
    drdy[0] = 1'b1;
    wait_done(0, 50, "t3", cyc);
    chk_str("t3_data_order", data_str(0), "a1,a2,a3,a4,");

    // Lock hold while the owner idles mid-burst
    do_reset();
    drdy[0] = 1'b1;
    add_beat(0, 0, 64'h10, 1'b0, 0);
    add_beat(0, 0, 64'h11, 1'b1, 5);
    add_beat(0, 1, 64'h20, 1'b1, 0);
    drive();
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      chk($sformatf("t4_req1_blocked_%0d", i), rdy[0][1], 0);
      chk($sformatf("t4_grant_%0d", i), gnt[0], 3'b001);
    end
    wait_done(0, 50, "t4", cyc);
    chk_str("t4_order", id_str(0), "001");

    // Asynchronous reset with the FIFO full and a burst locked
    do_reset();
    for (int b = 0; b < 4; b++) add_beat(0, 0, 64'hC0 + 64'(b), b == 3, 0);
    add_beat(0, 1, 64'hD0, 1'b1, 0);
    drive();
    repeat (2) step();
    chk("t5_locked", gnt[0], 3'b001);
    chk("t5_full_valid", dv[0], 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", dv[0], 0);
    chk("t5_async_grant", gnt[0], 0);
    clear_stim();
    step();
    rst_n = 1'b1;
    drdy[0] = 1'b1;
    add_beat(0, 0, 64'hE0, 1'b1, 0);
    add_beat(0, 1, 64'hE1, 1'b1, 0);
    drive();
    wait_done(0, 50, "t5", cyc);
    chk_str("t5_rr_cleared", id_str(0), "01");

    // Three requesters: channels 0 and 2 exercise the pointer wrap
    do_reset();
    drdy[1] = 1'b1;
    add_beat(1, 0, 64'h300, 1'b1, 0);
    add_beat(1, 0, 64'h301, 1'b1, 0);
    add_beat(1, 2, 64'h320, 1'b1, 0);
    add_beat(1, 2, 64'h321, 1'b1, 0);
    drive();
    wait_done(1, 50, "t6", cyc);
    chk_str("t6_wrap_order", id_str(1), "0202");

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
